// File: rtl/tile_lane_matrix.sv
// tile_lane_matrix: scrolling piano-tile lanes, key hit judge
// and row-scanned active-low LED dot matrix driver.
module tile_lane_matrix #(
    parameter int LANES     = 3,
    parameter int LANE_ROWS = 2,
    parameter int GAP_ROWS  = 1,
    parameter int ROWS      = 8,
    parameter int COLS      = 16,
    parameter int SCAN_DIV  = 5000,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [LANES-1:0] data,
    input  logic [LANES-1:0] key,
    input  logic             pause,
    output logic [ROWS-1:0]  dot_row,
    output logic [COLS-1:0]  dot_col,
    output logic             hit,
    output logic             miss,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] misses
);
    localparam int PITCH = LANE_ROWS + GAP_ROWS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int NW = $clog2(LANES + 1);
    localparam int SW = CNT_W + NW + 1;
    localparam logic [SW-1:0] MAXV =
        {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [LANES-1:0][COLS-1:0] r_lane;
    logic [DW-1:0]              r_cnt;
    logic [RW-1:0]              r_row;

    logic [LANES-1:0][COLS-1:0] w_lane_nxt;
    logic [LANES-1:0]           w_hit;
    logic [LANES-1:0]           w_miss;
    logic [SW-1:0]              w_nh;
    logic [SW-1:0]              w_nm;
    logic [SW-1:0]              w_score;
    logic [SW-1:0]              w_misses;
    logic                       w_wrap;
    logic [RW-1:0]              w_row_nxt;
    logic [COLS-1:0]            w_col;

    // Judge on the pre-shift hit line; a hit on a step cycle
    // simply lets the consumed tile fall off the end.
    always_comb begin
        w_lane_nxt = r_lane;
        w_hit      = '0;
        w_miss     = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!pause) begin
                w_hit[k]  = key[k] & r_lane[k][0];
                w_miss[k] = (key[k] & ~r_lane[k][0])
                          | (step & ~key[k] & r_lane[k][0]);
                if (step)
                    w_lane_nxt[k] = {data[k], r_lane[k][COLS-1:1]};
                else if (w_hit[k])
                    w_lane_nxt[k][0] = 1'b0;
            end
        end
    end

    always_comb begin
        w_nh = '0;
        w_nm = '0;
        for (int k = 0; k < LANES; k++) begin
            w_nh = w_nh + SW'(w_hit[k]);
            w_nm = w_nm + SW'(w_miss[k]);
        end
        w_score  = SW'(score) + w_nh;
        w_misses = SW'(misses) + w_nm;
        if (w_score > MAXV)
            w_score = MAXV;
        if (w_misses > MAXV)
            w_misses = MAXV;
    end

    assign w_wrap    = (r_cnt == DW'(SCAN_DIV - 1));
    assign w_row_nxt = (r_row == RW'(ROWS - 1)) ? '0
                     : r_row + RW'(1);

    // Column data is taken for the row being selected, so row
    // and column always change on the same edge.
    always_comb begin
        w_col = '0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(w_row_nxt) >= k * PITCH &&
                int'(w_row_nxt) < k * PITCH + LANE_ROWS)
                w_col = r_lane[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane  <= '0;
            r_cnt   <= '0;
            r_row   <= '0;
            dot_row <= '1;
            dot_col <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
            misses  <= '0;
        end else begin
            r_lane <= w_lane_nxt;
            hit    <= |w_hit;
            miss   <= |w_miss;
            score  <= w_score[CNT_W-1:0];
            misses <= w_misses[CNT_W-1:0];
            if (w_wrap) begin
                r_cnt   <= '0;
                r_row   <= w_row_nxt;
                dot_row <= ~(ROWS'(1) << (RW'(ROWS - 1) - w_row_nxt));
                dot_col <= w_col;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tile_lane_matrix.sv
// tb_tile_lane_matrix: table-driven judge/score vectors with a
// scoreboard queue, plus a lane model for the scanned display.
module tb_tile_lane_matrix;
    localparam int SD   = 4;
    localparam int ROWS = 8;
    localparam int COLS = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        step  = 1'b0;
    logic        pause = 1'b0;
    logic [2:0]  data  = '0;
    logic [2:0]  key   = '0;
    logic [7:0]  dot_row;
    logic [15:0] dot_col;
    logic        hit;
    logic        miss;
    logic [1:0]  score;
    logic [1:0]  misses;

    tile_lane_matrix #(
        .LANES(3), .LANE_ROWS(2), .GAP_ROWS(1), .ROWS(ROWS),
        .COLS(COLS), .SCAN_DIV(SD), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .data(data),
        .key(key), .pause(pause), .dot_row(dot_row),
        .dot_col(dot_col), .hit(hit), .miss(miss),
        .score(score), .misses(misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [2:0] d;
        logic [2:0] k;
        logic       p;
        logic       h;
        logic       m;
        logic [1:0] sc;
        logic [1:0] ms;
    } vec_t;

    typedef struct {
        logic       h;
        logic       m;
        logic [1:0] sc;
        logic [1:0] ms;
    } exp_t;

    vec_t        tv[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;
    logic [15:0] ml[3];
    logic [15:0] ecol;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic vn(input int n, input logic s,
                      input logic [2:0] d, input logic [2:0] k,
                      input logic p, input logic h, input logic m,
                      input logic [1:0] sc, input logic [1:0] ms);
        for (int i = 0; i < n; i++)
            tv.push_back('{s, d, k, p, h, m, sc, ms});
    endtask

    task automatic tick(input logic s, input logic [2:0] d,
                        input logic [2:0] k, input logic p);
        int         r;
        logic [7:0] erow;
        @(negedge clk);
        step  = s;
        data  = d;
        key   = k;
        pause = p;
        @(posedge clk);
        ncyc++;
        r = (ncyc / SD) % ROWS;
        if (ncyc % SD == 0) begin
            ecol = '0;
            if (r % 3 < 2)
                ecol = ml[r / 3];
        end
        for (int j = 0; j < 3; j++) begin
            if (!p) begin
                if (s)
                    ml[j] = {d[j], ml[j][15:1]};
                else if (k[j] && ml[j][0])
                    ml[j][0] = 1'b0;
            end
        end
        erow = (ncyc < SD) ? 8'hFF : ~(8'h80 >> r);
        #1;
        chk($sformatf("dot_row@%0d", ncyc), dot_row, erow);
        chk($sformatf("dot_col@%0d", ncyc), dot_col, ecol);
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        sb.push_back('{t.h, t.m, t.sc, t.ms});
        tick(t.s, t.d, t.k, t.p);
        e = sb.pop_front();
        chk($sformatf("hit[%0d]", idx), hit, e.h);
        chk($sformatf("miss[%0d]", idx), miss, e.m);
        chk($sformatf("score[%0d]", idx), score, e.sc);
        chk($sformatf("misses[%0d]", idx), misses, e.ms);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst  = 1'b1;
        ncyc = 0;
        ecol = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_row"}, dot_row, 8'hFF);
        chk({tag, "_col"}, dot_col, 16'h0);
        chk({tag, "_hit"}, hit, 1'b0);
        chk({tag, "_miss"}, miss, 1'b0);
        chk({tag, "_score"}, score, 2'd0);
        chk({tag, "_misses"}, misses, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        for (int j = 0; j < 3; j++)
            ml[j] = '0;
        ecol = '0;

        // idle scan after reset
        vn(36, 0, 3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0);
        // load lane0 bit0, then show it
        vn(1,  1, 3'b001, 3'b000, 0, 0, 0, 2'd0, 2'd0);
        vn(15, 1, 3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0);
        vn(32, 0, 3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0);
        // hit without step, then a clean step
        vn(1,  0, 3'b000, 3'b001, 0, 1, 0, 2'd1, 2'd0);
        vn(1,  1, 3'b000, 3'b000, 0, 0, 0, 2'd1, 2'd0);
        // lane1 escape, then wrong press on lane2
        vn(1,  1, 3'b010, 3'b000, 0, 0, 0, 2'd1, 2'd0);
        vn(15, 1, 3'b000, 3'b000, 0, 0, 0, 2'd1, 2'd0);
        vn(1,  1, 3'b000, 3'b000, 0, 0, 1, 2'd1, 2'd1);
        vn(1,  0, 3'b000, 3'b100, 0, 0, 1, 2'd1, 2'd2);
        // double hit on a step, then paused inputs
        vn(1,  1, 3'b011, 3'b000, 0, 0, 0, 2'd1, 2'd2);
        vn(15, 1, 3'b000, 3'b000, 0, 0, 0, 2'd1, 2'd2);
        vn(1,  1, 3'b100, 3'b011, 0, 1, 0, 2'd3, 2'd2);
        vn(1,  1, 3'b111, 3'b111, 1, 0, 0, 2'd3, 2'd2);
        vn(32, 0, 3'b000, 3'b000, 0, 0, 0, 2'd3, 2'd2);
        // fill lane0; lane2 tile escapes on the last step
        vn(15, 1, 3'b001, 3'b000, 0, 0, 0, 2'd3, 2'd2);
        vn(1,  1, 3'b001, 3'b000, 0, 0, 1, 2'd3, 2'd3);
        // saturation of both counters
        vn(5,  1, 3'b000, 3'b001, 0, 1, 0, 2'd3, 2'd3);
        vn(1,  1, 3'b000, 3'b011, 0, 1, 1, 2'd3, 2'd3);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        release_rst();

        foreach (tv[i])
            apply(tv[i], i);

        #2;
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        for (int j = 0; j < 3; j++)
            ml[j] = '0;
        release_rst();

        idle = '{0, 3'b000, 3'b000, 0, 0, 0, 2'd0, 2'd0};
        for (int i = 0; i < 10; i++)
            apply(idle, 1000 + i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_lane_matrix.md
Name: tile_lane_matrix

Overview:
- Parametrised scrolling tile display and hit judge for the piano-tile game.
- Holds one COLS-bit shift register per lane. On each scroll step it shifts new tile data in at the far column; the near column (bit 0) is the hit line.
- Judges player key presses against the hit line and counts hits and misses.
- Multiplexes lane contents onto an active-low row-scanned LED dot matrix.
- Sits between the tile pattern generator (data, step) and the board matrix pins; score feeds the 7-segment block.

Parameters:
LANES, 3, number of tile lanes
LANE_ROWS, 2, matrix rows lit per lane
GAP_ROWS, 1, blank rows between adjacent lanes
ROWS, 8, matrix rows; LANES*(LANE_ROWS+GAP_ROWS)-GAP_ROWS <= ROWS
COLS, 16, matrix columns (shift register length)
SCAN_DIV, 5000, clk cycles per row scan step (>=2)
CNT_W, 8, width of score and miss counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
step  in  1  one-cycle scroll strobe, synchronous to clk
data  in  LANES  tile bit entering each lane on step
key  in  LANES  one-cycle key press pulses, one per lane
pause  in  1  1 = freeze scrolling and judging
dot_row  out  ROWS  active-low row select, one-hot-low
dot_col  out  COLS  column drive for selected row, 1 = lit
hit  out  1  one-cycle pulse, at least one hit this cycle
miss  out  1  one-cycle pulse, at least one miss this cycle
score  out  CNT_W  saturating hit count
misses  out  CNT_W  saturating miss count

Behaviour:
- Reset: one clock; rst is asynchronous and active-low. While rst=0 the block holds these values:
  - all lane registers = 0, dot_row = all ones (blank), dot_col = 0
  - hit = miss = 0, score = misses = 0, scan counter = 0, row index = 0
- Reset mid-operation clears everything immediately; no partial state survives.
- Lane mapping: lane k drives rows k*(LANE_ROWS+GAP_ROWS) through k*(LANE_ROWS+GAP_ROWS)+LANE_ROWS-1. Every other row is blank (col = 0).
- Scroll: on a clk edge with step=1 and pause=0, for every lane k: lane[k] <= {data[k], lane[k][COLS-1:1]}. data enters at bit COLS-1; bit 0 exits.
- Judge: evaluated per lane in every cycle where pause=0. Always use the pre-shift bit 0 ("hl").
  - key[k]=1 and hl=1: hit for lane k. The tile is consumed: bit 0 is cleared, or, if step is also 1, the exiting bit is discarded with no miss.
  - key[k]=1 and hl=0: miss (wrong press).
  - step=1, key[k]=0 and hl=1: miss (tile escaped).
- Counting:
  - hit = OR of lane hits; miss = OR of lane misses. Both are registered, so they are high in the cycle after the event.
  - score increments by the number of lanes that hit that cycle; misses increments likewise. Both saturate at 2^CNT_W-1 and never wrap.
- Pause=1: step, data and key are ignored; no pulses are produced; the scan continues, so the display stays frozen but lit.
- Scan:
  - The counter runs 0..SCAN_DIV-1. In the cycle where it wraps, the row index advances by 1, wrapping from ROWS-1 to 0.
  - In that same cycle, dot_row and dot_col update together:
    - dot_row = all ones except bit ROWS-1-r low, where r is the new row index.
    - dot_col = current lane content for row r; blank rows give 0.
  - Row and column are always consistent, with no one-row skew.
  - Each row is held for exactly SCAN_DIV cycles.
  - The first row select appears SCAN_DIV cycles after reset release, with r=1. It then proceeds to r=2 and so on.
- Display content is sampled at scan time. A scroll in the middle of a row hold appears on the next row update, not glitched into the current one.
- Multiple lanes may hit and miss in the same cycle; hit and miss may both pulse together.

Test Plan:
1. Reset release, SCAN_DIV=4, idle:
   - dot_row = 8'hFF for 4 cycles.
   - Then 8'b10111111 (r=1) for 4 cycles, then 8'b11011111.
   - The row pattern repeats with period 32 cycles; dot_col = 0 throughout.
2. Scroll: data=3'b001 for 1 step, then 15 steps with data=0.
   - lane0 = 16'h0001.
   - Rows 0 and 1 show dot_col = 16'h0001; rows 2–7 show 0.
3. Hit: with lane0 bit0=1, pulse key=3'b001 (no step).
   - hit=1 on the next cycle; score 0→1; lane0 bit0 cleared.
   - A subsequent step produces no miss.
4. Escape and wrong press:
   - lane1 bit0=1, step with key=0: miss pulse, misses=1.
   - Then key=3'b100 with lane2 bit0=0: misses=2.
5. Simultaneous events:
   - step=1 and key=3'b011, with lane0 bit0=1 and lane1 bit0=1: score +2, no miss, both lanes shifted.
   - Then pause=1 with key=3'b111 and step=1: no change to lanes or counters.
6. Saturation with CNT_W=2: 5 hits → score stays at 3, then mid-frame rst=0 → all outputs are at their reset values within the same cycle.
